// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port, optional write-to-read
// forwarding, optional hardwired-zero r0 and a per-register pending-write scoreboard.
module regfile_sb #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter bit          ZERO_REG   = 1'b1,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reserve,
    input  logic [ADDR_WIDTH-1:0] reserve_addr,
    input  logic [ADDR_WIDTH-1:0] read_addr1,
    input  logic [ADDR_WIDTH-1:0] read_addr2,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    output logic                  busy1,
    output logic                  busy2,
    output logic [ADDR_WIDTH:0]   pending_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]      pending_q, pending_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  wr_en, rsv_en, cnt_inc, cnt_dec;

    logic [ADDR_WIDTH-1:0] raddr [2];
    logic [DATA_WIDTH-1:0] rdata [2];
    logic                  rbusy [2];

    assign wr_en  = write && !(ZERO_REG && (write_addr == '0));
    assign rsv_en = reserve && !(ZERO_REG && (reserve_addr == '0));

    // Reserve is applied after the write clear so a same-address re-reservation wins.
    always_comb begin
        pending_d = pending_q;
        if (wr_en) begin
            pending_d[write_addr] = 1'b0;
        end
        if (rsv_en) begin
            pending_d[reserve_addr] = 1'b1;
        end
    end

    assign cnt_inc = rsv_en && !pending_q[reserve_addr];
    assign cnt_dec = wr_en && pending_q[write_addr] && !(rsv_en && (reserve_addr == write_addr));

    always_comb begin
        count_d = count_q;
        if (cnt_inc && !cnt_dec) begin
            count_d = count_q + COUNT_ONE;
        end else if (!cnt_inc && cnt_dec) begin
            count_d = count_q - COUNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[write_addr] <= write_data;
        end
    end

    assign raddr[0] = read_addr1;
    assign raddr[1] = read_addr2;

    // A forwarded operand is never busy: its data is on the write port this cycle.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = '0;
            rbusy[p] = 1'b0;
            if (!reset && !(ZERO_REG && (raddr[p] == '0))) begin
                if (BYPASS && wr_en && (write_addr == raddr[p])) begin
                    rdata[p] = write_data;
                end else begin
                    rdata[p] = regs_q[raddr[p]];
                    rbusy[p] = pending_q[raddr[p]];
                end
            end
        end
    end

    assign read_data1    = rdata[0];
    assign read_data2    = rdata[1];
    assign busy1         = rbusy[0];
    assign busy2         = rbusy[1];
    assign pending_count = count_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: two configurations (zero-reg + bypass, plain + no bypass) share stimulus
// and are checked against an array-based model of the register file.
module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, write, reserve;
    logic [4:0]  write_addr, reserve_addr, read_addr1, read_addr2;
    logic [31:0] write_data;

    logic [1:0][31:0] rd1, rd2;
    logic [1:0]       b1, b2;
    logic [1:0][5:0]  cnt;

    regfile_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
        .clk(clk), .reset(reset), .write(write), .write_addr(write_addr),
        .write_data(write_data), .reserve(reserve), .reserve_addr(reserve_addr),
        .read_addr1(read_addr1), .read_addr2(read_addr2), .read_data1(rd1[0]),
        .read_data2(rd2[0]), .busy1(b1[0]), .busy2(b2[0]), .pending_count(cnt[0])
    );

    regfile_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
        .clk(clk), .reset(reset), .write(write), .write_addr(write_addr),
        .write_data(write_data), .reserve(reserve), .reserve_addr(reserve_addr),
        .read_addr1(read_addr1), .read_addr2(read_addr2), .read_data1(rd1[1]),
        .read_data2(rd2[1]), .busy1(b1[1]), .busy2(b2[1]), .pending_count(cnt[1])
    );

    typedef struct packed {
        logic [31:0]      cyc;
        logic [1:0][31:0] rd1, rd2;
        logic [1:0]       b1, b2;
        logic [1:0][5:0]  cnt;
    } exp_t;

    exp_t q[$];

    // Reference model: config 0 has zero-reg and bypass, config 1 has neither.
    logic [31:0] m_regs [2][32];
    logic        m_pend [2][32];
    int          cyc = 0;
    int          checks = 0;
    int          passed = 0;

    function automatic bit is_zero(int c, logic [4:0] a);
        return (c == 0) && (a == 5'd0);
    endfunction

    function automatic bit fwd(int c, logic w, logic [4:0] wa, logic [4:0] a);
        return (c == 0) && w && (wa == a) && !is_zero(c, a);
    endfunction

    function automatic logic [31:0] exp_rd(int c, logic rs, logic w, logic [4:0] wa,
                                           logic [31:0] wd, logic [4:0] a);
        if (rs || is_zero(c, a)) return 32'd0;
        if (fwd(c, w, wa, a)) return wd;
        return m_regs[c][a];
    endfunction

    function automatic logic exp_busy(int c, logic rs, logic w, logic [4:0] wa, logic [4:0] a);
        if (rs || is_zero(c, a) || fwd(c, w, wa, a)) return 1'b0;
        return m_pend[c][a];
    endfunction

    function automatic logic [5:0] popcount(int c);
        logic [5:0] n = 6'd0;
        for (int i = 0; i < 32; i++) n += {5'd0, m_pend[c][i]};
        return n;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[c][i] = 32'd0;
                m_pend[c][i] = 1'b0;
            end
        end
    endtask

    // Drive one cycle: apply inputs away from the edge, queue expectations, advance the model.
    task automatic step(input logic rs, input logic w, input logic [4:0] wa,
                        input logic [31:0] wd, input logic r, input logic [4:0] ra,
                        input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        reset = rs; write = w; write_addr = wa; write_data = wd;
        reserve = r; reserve_addr = ra; read_addr1 = a1; read_addr2 = a2;
        if (rs) model_clear();
        e.cyc = cyc;
        for (int c = 0; c < 2; c++) begin
            e.rd1[c] = exp_rd(c, rs, w, wa, wd, a1);
            e.rd2[c] = exp_rd(c, rs, w, wa, wd, a2);
            e.b1[c]  = exp_busy(c, rs, w, wa, a1);
            e.b2[c]  = exp_busy(c, rs, w, wa, a2);
            e.cnt[c] = popcount(c);
        end
        q.push_back(e);
        @(posedge clk);
        cyc++;
        if (!rs) begin
            for (int c = 0; c < 2; c++) begin
                if (w && !is_zero(c, wa)) begin
                    m_regs[c][wa] = wd;
                    m_pend[c][wa] = 1'b0;
                end
                if (r && !is_zero(c, ra)) m_pend[c][ra] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic chk(input string name, input int c, input logic [31:0] cy,
                       input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s cfg=%0d cyc=%0d got=%h expected=%h", name, c, cy, got, want);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int c = 0; c < 2; c++) begin
                    chk("read_data1", c, e.cyc, rd1[c], e.rd1[c]);
                    chk("read_data2", c, e.cyc, rd2[c], e.rd2[c]);
                    chk("busy1", c, e.cyc, {31'd0, b1[c]}, {31'd0, e.b1[c]});
                    chk("busy2", c, e.cyc, {31'd0, b2[c]}, {31'd0, e.b2[c]});
                    chk("pending_count", c, e.cyc, {26'd0, cnt[c]}, {26'd0, e.cnt[c]});
                end
            end
        end
    end

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        logic [4:0] wa;
        int         waited;
        reset = 1'b1; write = 1'b0; reserve = 1'b0; write_data = '0;
        write_addr = '0; reserve_addr = '0; read_addr1 = '0; read_addr2 = '0;
        model_clear();
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // Reset clear, issued mid-cycle with a write and reserve pending on the inputs
        step(0, 1, 5, 32'hDEADBEEF, 1, 6, 5, 6);
        step(0, 0, 0, 0, 0, 0, 5, 6);
        step(1, 1, 5, 32'h11111111, 1, 5, 5, 6);
        step(0, 0, 0, 0, 0, 0, 5, 6);
        // Bypass
        step(0, 1, 7, 32'h12345678, 0, 0, 7, 5);
        step(0, 0, 0, 0, 0, 0, 7, 7);
        // Zero register
        step(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 7);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // Scoreboard set/release
        step(0, 0, 0, 0, 1, 3, 3, 0);
        step(0, 0, 0, 0, 0, 0, 3, 3);
        step(0, 1, 3, 32'h000000A5, 0, 0, 3, 0);
        step(0, 0, 0, 0, 0, 0, 3, 3);
        // Simultaneous write and reserve on a pending register
        step(0, 0, 0, 0, 1, 9, 9, 9);
        step(0, 1, 9, 32'h99999999, 1, 9, 9, 9);
        step(0, 0, 0, 0, 0, 0, 9, 9);
        // Count saturation
        for (int i = 0; i < 32; i++) step(0, 0, 0, 0, 1, 5'(i), 5'(i), 4);
        step(0, 0, 0, 0, 1, 4, 4, 0);
        step(0, 1, 4, 32'h44444444, 0, 0, 4, 0);
        step(0, 0, 0, 0, 0, 0, 4, 0);
        // Randomised traffic with occasional resets
        for (int n = 0; n < 2000; n++) begin
            wa = rand_addr();
            step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), wa, $urandom,
                 1'($urandom_range(0, 1)), rand_addr(),
                 ($urandom_range(0, 2) == 0) ? wa : rand_addr(), rand_addr());
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain got=%0d pending expectations, expected=0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with write-to-read bypass, optional hardwired-zero register, asynchronous clear, and a per-register pending-write scoreboard. It is the next-generation architectural register file for the pipelined core. The decode stage reads two operands and reserves a destination register. The writeback stage writes results and releases those reservations. The scoreboard tells decode when an operand is still in flight, so decode can stall.

## Interface

Parameters:
- DATA_WIDTH, 32: bits per register.
- ADDR_WIDTH, 5: address width; depth = 2**ADDR_WIDTH.
- ZERO_REG, 1: when 1, register 0 reads as 0 and ignores writes and reservations.
- BYPASS, 1: when 1, a same-cycle write is forwarded to the read ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all registers and all pending bits.
- write  in  1  write enable (writeback stage).
- write_addr  in  ADDR_WIDTH  destination of the write.
- write_data  in  DATA_WIDTH  write data.
- reserve  in  1  marks reserve_addr pending (decode issued a writer).
- reserve_addr  in  ADDR_WIDTH  register to reserve.
- read_addr1, read_addr2  in  ADDR_WIDTH  operand addresses.
- read_data1, read_data2  out  DATA_WIDTH  operand data (combinational).
- busy1, busy2  out  1  operand register has an outstanding writer (combinational).
- pending_count  out  ADDR_WIDTH+1  number of registers whose pending bit is set (registered).

## Operation

- Storage: 2**ADDR_WIDTH × DATA_WIDTH data array, plus a pending bit per entry, plus the pending_count counter.
- Reset (asynchronous): every register = 0, every pending bit = 0, pending_count = 0.
  - Outputs during reset: read_data = 0, busy = 0.
  - Any write or reserve sampled while reset is high is discarded.
- Write (write=1 at edge): registers[write_addr] <= write_data; pending[write_addr] <= 0.
- Reserve (reserve=1 at edge): pending[reserve_addr] <= 1.
- Write and reserve to the same address in one cycle: data is written and pending ends at 1, because the newer writer wins.
- Write and reserve to different addresses in one cycle: both take effect.
- Write to a non-pending register: data is written; pending stays 0; count unchanged.
- Reserve of an already-pending register: pending stays 1; count unchanged.
- pending_count update per edge: new count = popcount of the next pending vector.
  - Implement it incrementally: +1 if the reserve sets a bit that was 0; −1 if the write clears a bit that was 1 and the same cycle does not re-reserve it.
  - Range is 0..2**ADDR_WIDTH; it never wraps.
- ZERO_REG=1 and address 0:
  - Writes are ignored, and so is the write's bypass.
  - Reserve is ignored and pending[0] stays 0.
  - read_data = 0 and busy = 0.
- Read path, per port n:
  - If BYPASS=1 and write=1 and write_addr==read_addrn (and not the zero register): read_datan = write_data.
  - Otherwise read_datan = registers[read_addrn].
- Busy path, per port n:
  - busyn = pending[read_addrn].
  - If BYPASS=1 and that same forwarding condition holds: busyn = 0, because the data is present this cycle.
  - BYPASS=0: busy reflects the stored pending bit only.
- The same-cycle reserve never affects busy or read_data in that cycle.

## Timing

- Read latency: 0 cycles (combinational from the address and stored state).
- Write latency: data is visible in storage after the rising edge.
  - BYPASS=1: also visible in the same cycle through forwarding.
  - BYPASS=0: visible from the next cycle only.
- Pending bits and pending_count update on the rising edge; busy reflects a new reservation from the cycle after the reserve.
- Reset assertion takes effect immediately, with no clock needed.
- On reset deassertion, the first edge with write or reserve high updates state normally.

## Test plan

- Reset clear:
  - Write 0xDEADBEEF to r5.
  - Assert reset mid-cycle, without a clock edge.
  - Required: read_data1 (addr 5) = 0 immediately, and pending_count = 0.
- Bypass:
  - BYPASS=1: write=1, write_addr=7, write_data=0x12345678, read_addr1=7 → read_data1 = 0x12345678 in the same cycle.
  - BYPASS=0: same stimulus → old value in that cycle, 0x12345678 after the edge.
- Zero register (ZERO_REG=1):
  - Write 0xFFFFFFFF to r0 and reserve r0.
  - Required: read_data1 = 0, busy1 = 0, pending_count unchanged.
- Scoreboard:
  - Reserve r3 → next cycle busy1 (addr 3) = 1 and pending_count = 1.
  - Write r3 = 0xA5 → busy1 = 0 in the write cycle (BYPASS=1); pending_count = 0 after the edge.
- Simultaneous write and reserve on r9 while r9 is pending:
  - Required: data updated, busy stays 1 after the edge, pending_count unchanged.
- Count saturation:
  - ZERO_REG=0: reserve all 32 registers, one per cycle → pending_count = 32.
  - Reserve r4 again → still 32.
  - Write r4 → 31.
